acc_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 8-bit accumulator datapath. It accepts one decoded opcode at a time from the fetch stage over a valid/ready handshake. It drives the accumulator source select and write enable, register-file write, and memory read/write strobes, and inserts wait states for memory loads. It sits between fetch/decode and the accumulator, register file and data memory, and counts retired instructions.

---
 rtl/acc_sequencer_if.sv | 10 +
 rtl/acc_sequencer.sv | 133 +++++++++++++
 tb/tb_acc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_sequencer_if.sv
// Fetch-to-sequencer opcode handshake: fetch presents an opcode, the sequencer
// accepts it on a clock edge where both valid and ready are high.
interface acc_sequencer_if;
  logic       instr_valid;
  logic [3:0] instr_op;
  logic       instr_ready;

  modport master (output instr_valid, output instr_op, input  instr_ready);
  modport slave  (input  instr_valid, input  instr_op, output instr_ready);
endinterface

// File: rtl/acc_sequencer.sv
// Multi-cycle control FSM for the 8-bit accumulator datapath: decodes one opcode
// at a time, drives accumulator/regfile/memory strobes and counts retired instructions.
module acc_sequencer #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  acc_sequencer_if.slave   instr,
  output logic [1:0]       acc_sel,
  output logic             acc_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             done,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_LDM  = 4'h3;
  localparam logic [3:0] OP_STM  = 4'h4;
  localparam logic [3:0] OP_STR  = 4'h5;
  localparam logic [3:0] OP_ALU  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] SEL_IMM = 2'd0;
  localparam logic [1:0] SEL_REG = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_ALU = 2'd3;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MWAIT,
    S_WB,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [3:0]       wait_q, wait_d;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      op_q      <= 4'h0;
      wait_q    <= 4'h0;
      sel_q     <= SEL_IMM;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      sel_q     <= acc_sel;
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, done};
    end
  end

  assign retired = retired_q;

  // acc_sel is registered through sel_q so it keeps its last driven value
  // in every cycle where the accumulator is not being steered.
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    wait_d            = wait_q;
    instr.instr_ready = 1'b0;
    acc_sel           = sel_q;
    acc_write         = 1'b0;
    reg_write         = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    done              = 1'b0;
    illegal           = 1'b0;
    halted            = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr.instr_ready = 1'b1;
        if (instr.instr_valid) begin
          op_d    = instr.instr_op;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_IDLE;
        case (op_q)
          OP_NOP:  done = 1'b1;
          OP_LDI:  begin acc_write = 1'b1; acc_sel = SEL_IMM; done = 1'b1; end
          OP_LDR:  begin acc_write = 1'b1; acc_sel = SEL_REG; done = 1'b1; end
          OP_ALU:  begin acc_write = 1'b1; acc_sel = SEL_ALU; done = 1'b1; end
          OP_STM:  begin mem_write = 1'b1; done = 1'b1; end
          OP_STR:  begin reg_write = 1'b1; done = 1'b1; end
          OP_LDM:  begin
            mem_read = 1'b1;
            wait_d   = LAT4;
            state_d  = (LAT4 != 4'd0) ? S_MWAIT : S_WB;
          end
          OP_HALT: begin done = 1'b1; state_d = S_HALT; end
          default: begin done = 1'b1; illegal = 1'b1; end
        endcase
      end

      S_MWAIT: begin
        mem_read = 1'b1;
        acc_sel  = SEL_MEM;
        wait_d   = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = S_WB;
      end

      S_WB: begin
        acc_sel   = SEL_MEM;
        acc_write = 1'b1;
        done      = 1'b1;
        state_d   = S_IDLE;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: a driver issues opcodes and queues the
// expected retirement, a negedge monitor compares each retired instruction.
module tb_acc_sequencer;

  localparam int LAT_M = 2;
  localparam int CW    = 4;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDR = 4'h2, OP_LDM = 4'h3,
                         OP_STM = 4'h4, OP_STR = 4'h5, OP_ALU = 4'h6, OP_HALT = 4'hF;

  typedef struct {
    logic       ill;
    logic       aw;
    logic [1:0] sel;
    logic       rw;
    logic       mw;
    logic       halt;
    int         lat;
    int         mreads;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, rst_b;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  acc_sequencer_if if_m ();
  acc_sequencer_if if_b0 ();
  acc_sequencer_if if_b4 ();

  logic [1:0]    m_sel, b0_sel, b4_sel;
  logic          m_aw, m_rw, m_mr, m_mw, m_done, m_ill, m_halt;
  logic          b0_aw, b0_rw, b0_mr, b0_mw, b0_done, b0_ill, b0_halt;
  logic          b4_aw, b4_rw, b4_mr, b4_mw, b4_done, b4_ill, b4_halt;
  logic [CW-1:0] m_ret;
  logic [15:0]   b0_ret, b4_ret;

  logic       b_valid;
  logic [3:0] b_op;
  assign if_b0.instr_valid = b_valid;
  assign if_b0.instr_op    = b_op;
  assign if_b4.instr_valid = b_valid;
  assign if_b4.instr_op    = b_op;

  acc_sequencer #(.MEM_LAT(LAT_M), .CNT_W(CW)) u_dut (
    .CLK(clk), .RST_N(rst_n), .instr(if_m), .acc_sel(m_sel), .acc_write(m_aw),
    .reg_write(m_rw), .mem_read(m_mr), .mem_write(m_mw), .done(m_done),
    .illegal(m_ill), .halted(m_halt), .retired(m_ret));

  acc_sequencer #(.MEM_LAT(0), .CNT_W(16)) u_lat0 (
    .CLK(clk), .RST_N(rst_b), .instr(if_b0), .acc_sel(b0_sel), .acc_write(b0_aw),
    .reg_write(b0_rw), .mem_read(b0_mr), .mem_write(b0_mw), .done(b0_done),
    .illegal(b0_ill), .halted(b0_halt), .retired(b0_ret));

  acc_sequencer #(.MEM_LAT(4), .CNT_W(16)) u_lat4 (
    .CLK(clk), .RST_N(rst_b), .instr(if_b4), .acc_sel(b4_sel), .acc_write(b4_aw),
    .reg_write(b4_rw), .mem_read(b4_mr), .mem_write(b4_mw), .done(b4_done),
    .illegal(b4_ill), .halted(b4_halt), .retired(b4_ret));

  exp_t sb_q[$];
  int   acc_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference behaviour of one opcode, straight from the opcode table.
  function automatic exp_t model(input logic [3:0] op);
    exp_t e;
    e = '{ill: 1'b0, aw: 1'b0, sel: 2'd0, rw: 1'b0, mw: 1'b0, halt: 1'b0, lat: 0, mreads: 0};
    case (op)
      OP_NOP:  ;
      OP_LDI:  begin e.aw = 1'b1; e.sel = 2'd0; end
      OP_LDR:  begin e.aw = 1'b1; e.sel = 2'd1; end
      OP_ALU:  begin e.aw = 1'b1; e.sel = 2'd3; end
      OP_LDM:  begin e.aw = 1'b1; e.sel = 2'd2; e.lat = 1 + LAT_M; e.mreads = 1 + LAT_M; end
      OP_STM:  e.mw = 1'b1;
      OP_STR:  e.rw = 1'b1;
      OP_HALT: e.halt = 1'b1;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: all outputs are Moore, so sample them mid-cycle on the negedge.
  bit         inflight = 1'b0;
  bit         halted_m = 1'b0;
  int         mon_cyc  = 0;
  int         mreads   = 0;
  int         mdl_ret  = 0;
  logic [1:0] mdl_sel  = 2'd0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      inflight = 1'b0; halted_m = 1'b0; mdl_ret = 0; mdl_sel = 2'd0;
    end else begin
      if (inflight) begin
        if (m_mr) mreads++;
        if (32'(m_aw) + 32'(m_rw) + 32'(m_mw) > 1) check("write_onehot", {m_aw, m_rw, m_mw}, 0);
        if (m_done) begin
          inflight = 1'b0;
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("latency", mon_cyc, e.lat);
            check("mem_read_cycles", mreads, e.mreads);
            check("illegal", m_ill, e.ill);
            check("acc_write", m_aw, e.aw);
            check("reg_write", m_rw, e.rw);
            check("mem_write", m_mw, e.mw);
            if (e.aw) check("acc_sel", m_sel, e.sel);
            check("retired_at_done", m_ret, mdl_ret);
            mdl_ret = (mdl_ret + 1) % (1 << CW);
            if (e.aw) mdl_sel = e.sel;
            if (e.halt) halted_m = 1'b1;
          end
        end else begin
          if (m_ill) check("illegal_without_done", m_ill, 0);
          mon_cyc++;
          if (mon_cyc > 30) begin
            check("done_timeout", 0, 1);
            inflight = 1'b0;
          end
        end
      end else if (halted_m) begin
        check("halted", m_halt, 1);
        check("halt_ready", if_m.instr_ready, 0);
        check("halt_strobes", {m_aw, m_rw, m_mr, m_mw, m_done}, 0);
      end else begin
        check("idle_ready", if_m.instr_ready, 1);
        check("idle_strobes", {m_aw, m_rw, m_mr, m_mw, m_done, m_ill, m_halt}, 0);
        check("idle_acc_sel", m_sel, mdl_sel);
        check("idle_retired", m_ret, mdl_ret);
      end
      if (!inflight && !halted_m && if_m.instr_ready && if_m.instr_valid) begin
        inflight = 1'b1; mon_cyc = 0; mreads = 0;
      end
    end
  end

  // Present op after gap idle cycles; queue its expectation at the accepting edge.
  task automatic issue(input logic [3:0] op, input int gap);
    bit ok = 1'b0;
    repeat (gap) begin
      if_m.instr_valid = 1'b0;
      @(posedge clk); #1;
    end
    if_m.instr_valid = 1'b1;
    if_m.instr_op    = op;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (if_m.instr_ready) begin
        sb_q.push_back(model(op));
        acc_cyc = cyc_cnt;
        ok = 1'b1;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if_m.instr_valid = 1'b0;
    if_m.instr_op    = 4'($urandom_range(0, 15));
  endtask

  task automatic reset_main();
    @(posedge clk); #2;
    rst_n = 1'b0;
    if_m.instr_valid = 1'b0;
    sb_q.delete();
    #1;
    check("rst_ready", if_m.instr_ready, 1);
    check("rst_strobes", {m_aw, m_rw, m_mr, m_mw, m_done, m_ill, m_halt}, 0);
    check("rst_retired", m_ret, 0);
    check("rst_acc_sel", m_sel, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic halt_phase();
    issue(OP_HALT, 0);
    if_m.instr_valid = 1'b1;
    repeat (12) begin
      if_m.instr_op = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    if_m.instr_valid = 1'b0;
    reset_main();
    #1 check("halt_cleared_by_reset", m_halt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [5];
    logic [3:0] op;
    int prev;
    seq[0] = OP_LDI; seq[1] = OP_LDR; seq[2] = OP_ALU; seq[3] = OP_STR; seq[4] = OP_STM;

    rst_n = 1'b0; rst_b = 1'b0;
    if_m.instr_valid = 1'b0; if_m.instr_op = 4'h0;
    b_valid = 1'b0; b_op = 4'h0;
    #1;
    check("por_ready", if_m.instr_ready, 1);
    check("por_strobes", {m_aw, m_rw, m_mr, m_mw, m_done, m_ill, m_halt}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1; rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // MEM_LAT=0 and MEM_LAT=4 instances run the same LDM; reset lands in u_lat4's 2nd MWAIT.
    b_op = OP_LDM; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("lat0_exec_mem_read", {b0_mr, b0_aw, b0_done}, 3'b100);
    check("lat4_exec_mem_read", {b4_mr, b4_aw, b4_done}, 3'b100);
    @(posedge clk); #1;
    check("lat0_wb", {b0_mr, b0_aw, b0_done, b0_sel}, 5'b01110);
    check("lat4_mwait1", {b4_mr, b4_aw, b4_done, b4_sel}, 5'b10010);
    @(posedge clk); #1;
    check("lat0_idle_ready", b0_ret, 1);
    check("lat0_sel_hold", {if_b0.instr_ready, b0_sel}, 3'b110);
    check("lat4_mwait2", b4_mr, 1);
    #1 rst_b = 1'b0;
    #1;
    check("lat4_rst_mem_read_async", b4_mr, 0);
    check("lat4_rst_no_done", b4_done, 0);
    check("lat4_rst_retired", b4_ret, 0);
    repeat (2) @(posedge clk);
    #2 rst_b = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("lat4_after_rst_idle", {if_b4.instr_ready, b4_mr, b4_done}, 3'b100);
    check("lat4_after_rst_retired", b4_ret, 0);

    // Back-to-back single-cycle ops with valid held high.
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      issue(seq[i], 0);
      if (i > 0) check("b2b_spacing", acc_cyc - prev, 2);
      prev = acc_cyc;
    end
    repeat (2) @(posedge clk); #1;
    check("b2b_retired", m_ret, 5);

    issue(OP_LDM, 1);
    issue(4'h9, 1);
    repeat (2) @(posedge clk); #1;
    check("after_ill_retired", m_ret, 7);
    halt_phase();

    // Reset in the second MWAIT cycle of an LDM on the main instance.
    issue(OP_LDM, 2);
    repeat (2) @(posedge clk);
    #2 check("mid_ldm_mem_read", m_mr, 1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_ldm_rst_mem_read", m_mr, 0);
    check("mid_ldm_rst_done", m_done, 0);
    check("mid_ldm_rst_retired", m_ret, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("mid_ldm_idle", {if_m.instr_ready, m_mr}, 2'b10);

    // Counter wrap: 17 NOPs from zero.
    reset_main();
    for (int i = 0; i < 17; i++) issue(OP_NOP, $urandom_range(0, 1));
    repeat (2) @(posedge clk); #1;
    check("wrap_retired", m_ret, 17 % (1 << CW));

    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == OP_HALT) halt_phase();
      else issue(op, $urandom_range(0, 2));
    end
    repeat (10) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
